// File: rtl/project_soc_onchip_mem_arbiter_if.sv
// Avalon-MM requester port bundle between one master and the on-chip RAM arbiter.
// The lock signal exists only when ONCHIP_ARB_LOCK_EN is defined.
interface project_soc_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
`ifdef ONCHIP_ARB_LOCK_EN
  logic              lock;

  modport master (
    output address, byteenable, read, write, writedata, lock,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata, lock,
    output waitrequest, readdata, readdatavalid
  );
`else
  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );
  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
`endif
endinterface

// File: rtl/project_soc_onchip_mem_arbiter.sv
// Round-robin two-master arbiter for a single-port on-chip RAM (1-cycle read latency, waitrequest to loser).
// Optional ONCHIP_ARB_LOCK_EN adds per-master lock for atomic read-modify-write sequences.
module project_soc_onchip_mem_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  project_soc_onchip_mem_arbiter_if.slave m0,
  project_soc_onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]              mem_address,
  output logic [BE_W-1:0]                mem_byteenable,
  output logic                           mem_chipselect,
  output logic                           mem_write,
  output logic [DATA_W-1:0]              mem_writedata,
  output logic                           mem_clken,
  input  logic [DATA_W-1:0]              mem_readdata
);
  logic req0, req1;
  logic grant0, grant1;
  logic accept;
  logic sel_wr;
  logic last_grant;
  logic rd_pend;
  logic rd_owner;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

`ifdef ONCHIP_ARB_LOCK_EN
  logic lock_vld;
  logic lock_owner;
  logic sel_lock;
`endif

  // last_grant holds the index of the previous winner; the other master wins a tie
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      grant0 = req0 & (~req1 | last_grant);
      grant1 = req1 & ~grant0;
`ifdef ONCHIP_ARB_LOCK_EN
      if (lock_vld) begin
        grant0 = req0 & ~lock_owner;
        grant1 = req1 & lock_owner;
      end
`endif
    end
  end

  assign accept = grant0 | grant1;
  assign sel_wr = grant1 ? m1.write : m0.write;

  assign mem_chipselect = accept;
  assign mem_write      = accept & sel_wr;
  assign mem_address    = grant1 ? m1.address : m0.address;
  assign mem_writedata  = grant1 ? m1.writedata : m0.writedata;
  assign mem_byteenable = sel_wr ? (grant1 ? m1.byteenable : m0.byteenable) : {BE_W{1'b1}};
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = req0 & ~grant0;
  assign m1.waitrequest = req1 & ~grant1;

  // Read data bus is shared; only the owner of the pending read sees a valid pulse
  assign m0.readdata      = mem_readdata;
  assign m1.readdata      = mem_readdata;
  assign m0.readdatavalid = rd_pend & ~rd_owner & ~reset;
  assign m1.readdatavalid = rd_pend &  rd_owner & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      rd_pend <= accept & ~sel_wr;
      if (accept) begin
        last_grant <= grant1;
        rd_owner   <= grant1;
      end
    end
  end

`ifdef ONCHIP_ARB_LOCK_EN
  assign sel_lock = grant1 ? m1.lock : m0.lock;

  // While locked only the owner can be accepted, so an unlocked accept always releases
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_vld   <= 1'b0;
      lock_owner <= 1'b0;
    end else if (accept) begin
      if (sel_lock) begin
        lock_vld   <= 1'b1;
        lock_owner <= grant1;
      end else begin
        lock_vld   <= 1'b0;
      end
    end
  end
`endif
endmodule

// File: tb/tb_project_soc_onchip_mem_arbiter.sv
// Directed bench for the on-chip RAM arbiter with a behavioural single-port RAM (registered address, unregistered q).
module tb_project_soc_onchip_mem_arbiter;
  logic        clk;
  logic        reset;
  logic [1:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic        mem_clken;
  logic [31:0] mem_readdata;

  int checks = 0;
  int errors = 0;

  project_soc_onchip_mem_arbiter_if #(.ADDR_W(2), .DATA_W(32), .BE_W(4)) m0_if ();
  project_soc_onchip_mem_arbiter_if #(.ADDR_W(2), .DATA_W(32), .BE_W(4)) m1_if ();

  project_soc_onchip_mem_arbiter #(.ADDR_W(2), .DATA_W(32), .BE_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .m0             (m0_if),
    .m1             (m1_if),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model
  logic [31:0] ram [4];
  logic [1:0]  ram_addr_q;
  logic        ram_load;

  always @(posedge clk) begin
    if (ram_load) begin
      ram[0] <= 32'h1234_5678;
      ram[1] <= 32'h0BAD_F00D;
      ram[2] <= 32'hCAFE_0002;
      ram[3] <= 32'hBEEF_0003;
    end else if (mem_clken) begin
      ram_addr_q <= mem_address;
      if (mem_chipselect && mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic rd, input logic wr, input logic [1:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a; m0_if.writedata = d; m0_if.byteenable = be;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a; m1_if.writedata = d; m1_if.byteenable = be;
    end
  endtask

  task automatic idle_all();
    drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int g;
    int prev;
    reset    = 1'b1;
    ram_load = 1'b1;
    idle_all();
`ifdef ONCHIP_ARB_LOCK_EN
    m0_if.lock = 1'b0;
    m1_if.lock = 1'b0;
`endif
    // Reset state, with m0 requesting during reset
    drive(0, 1'b1, 1'b0, 2'd2, 32'h0, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    ram_load = 1'b0;
    #1;
    chk("rst_cs", mem_chipselect, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_clken", mem_clken, 1'b1);
    chk("rst_rdv0", m0_if.readdatavalid, 1'b0);
    chk("rst_rdv1", m1_if.readdatavalid, 1'b0);
    chk("rst_wait0", m0_if.waitrequest, 1'b1);

    // m0 read addr 2 alone
    @(negedge clk); reset = 1'b0; #1;
    chk("t1_wait0", m0_if.waitrequest, 1'b0);
    chk("t1_cs", mem_chipselect, 1'b1);
    chk("t1_addr", mem_address, 2'd2);
    chk("t1_wr", mem_write, 1'b0);
    chk("t1_be", mem_byteenable, 4'hF);
    @(negedge clk); idle_all(); #1;
    chk("t1_rdv0", m0_if.readdatavalid, 1'b1);
    chk("t1_rdata", m0_if.readdata, 32'hCAFE_0002);
    chk("t1_rdv1", m1_if.readdatavalid, 1'b0);
    chk("t1_cs_idle", mem_chipselect, 1'b0);

    // Both write addr 1 in the same cycle
    do_reset();
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 2'd1, 32'h1111_1111, 4'hF);
    drive(1, 1'b0, 1'b1, 2'd1, 32'h2222_2222, 4'hF);
    #1;
    chk("t2_wait0", m0_if.waitrequest, 1'b0);
    chk("t2_wait1", m1_if.waitrequest, 1'b1);
    chk("t2_wr", mem_write, 1'b1);
    chk("t2_wdata0", mem_writedata, 32'h1111_1111);
    chk("t2_addr", mem_address, 2'd1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0); #1;
    chk("t2_wait1_b", m1_if.waitrequest, 1'b0);
    chk("t2_wdata1", mem_writedata, 32'h2222_2222);
    @(negedge clk); drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0); drive(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'h0); #1;
    chk("t2_rd_cs", mem_chipselect, 1'b1);
    chk("t2_rd_wr", mem_write, 1'b0);
    @(negedge clk); idle_all(); #1;
    chk("t2_rdv0", m0_if.readdatavalid, 1'b1);
    chk("t2_rdata", m0_if.readdata, 32'h2222_2222);

    // Both hold reads for 6 cycles: grants alternate starting with m0
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i < 6) begin
        drive(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 2'd3, 32'h0, 4'h0);
      end else begin
        idle_all();
      end
      #1;
      if (i < 6) begin
        g = i % 2;
        chk($sformatf("t3_wait0_%0d", i), m0_if.waitrequest, (g == 1));
        chk($sformatf("t3_wait1_%0d", i), m1_if.waitrequest, (g == 0));
        chk($sformatf("t3_addr_%0d", i), mem_address, (g == 1) ? 2'd3 : 2'd0);
      end
      if (i == 0) begin
        chk("t3_rdv0_first", m0_if.readdatavalid, 1'b0);
        chk("t3_rdv1_first", m1_if.readdatavalid, 1'b0);
      end else begin
        prev = (i - 1) % 2;
        chk($sformatf("t3_rdv0_%0d", i), m0_if.readdatavalid, (prev == 0));
        chk($sformatf("t3_rdv1_%0d", i), m1_if.readdatavalid, (prev == 1));
        chk($sformatf("t3_rdata_%0d", i), (prev == 1) ? m1_if.readdata : m0_if.readdata,
            (prev == 1) ? 32'hBEEF_0003 : 32'h1234_5678);
      end
    end

    // Byte-lane write
    @(negedge clk); drive(0, 1'b0, 1'b1, 2'd0, 32'h0000_0000, 4'hF); #1;
    chk("t4_wr0", mem_write, 1'b1);
    chk("t4_be0", mem_byteenable, 4'hF);
    @(negedge clk); drive(0, 1'b0, 1'b1, 2'd0, 32'hAABB_CCDD, 4'b0010); #1;
    chk("t4_be1", mem_byteenable, 4'b0010);
    chk("t4_wdata", mem_writedata, 32'hAABB_CCDD);
    @(negedge clk); drive(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'b0010); #1;
    chk("t4_rd_be", mem_byteenable, 4'hF);
    chk("t4_rd_wr", mem_write, 1'b0);
    @(negedge clk); idle_all(); #1;
    chk("t4_rdv0", m0_if.readdatavalid, 1'b1);
    chk("t4_rdata", m0_if.readdata, 32'h0000_CC00);

    // Reset right after an accepted read
    @(negedge clk); drive(0, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0); #1;
    chk("t5_wait0", m0_if.waitrequest, 1'b0);
    @(negedge clk); reset = 1'b1; idle_all(); #1;
    chk("t5_rdv0_rst", m0_if.readdatavalid, 1'b0);
    chk("t5_rdv1_rst", m1_if.readdatavalid, 1'b0);
    chk("t5_cs_rst", mem_chipselect, 1'b0);
    @(negedge clk); reset = 1'b0;
    drive(0, 1'b1, 1'b0, 2'd1, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 2'd3, 32'h0, 4'h0);
    #1;
    chk("t5_rdv0_post", m0_if.readdatavalid, 1'b0);
    chk("t5_rdv1_post", m1_if.readdatavalid, 1'b0);
    chk("t5_wait0_post", m0_if.waitrequest, 1'b0);
    chk("t5_wait1_post", m1_if.waitrequest, 1'b1);
    @(negedge clk); drive(0, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0); #1;
    chk("t5_wait1_b", m1_if.waitrequest, 1'b0);
    chk("t5_rdv0_b", m0_if.readdatavalid, 1'b1);
    chk("t5_rdata0", m0_if.readdata, 32'h2222_2222);
    @(negedge clk); idle_all(); #1;
    chk("t5_rdv1_c", m1_if.readdatavalid, 1'b1);
    chk("t5_rdata1", m1_if.readdata, 32'hBEEF_0003);

`ifdef ONCHIP_ARB_LOCK_EN
    // Locked read-modify-write by m1 holds off m0
    do_reset();
    @(negedge clk); drive(1, 1'b1, 1'b0, 2'd2, 32'h0, 4'h0); m1_if.lock = 1'b1; #1;
    chk("lk_wait1", m1_if.waitrequest, 1'b0);
    @(negedge clk); drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0); m1_if.lock = 1'b0;
    drive(0, 1'b1, 1'b0, 2'd0, 32'h0, 4'h0); #1;
    chk("lk_wait0_a", m0_if.waitrequest, 1'b1);
    chk("lk_cs_a", mem_chipselect, 1'b0);
    chk("lk_rdv1", m1_if.readdatavalid, 1'b1);
    chk("lk_rdata1", m1_if.readdata, 32'hCAFE_0002);
    @(negedge clk); drive(1, 1'b0, 1'b1, 2'd2, 32'h5A5A_5A5A, 4'hF); #1;
    chk("lk_wait0_b", m0_if.waitrequest, 1'b1);
    chk("lk_wait1_b", m1_if.waitrequest, 1'b0);
    chk("lk_wr_b", mem_write, 1'b1);
    @(negedge clk); drive(1, 1'b0, 1'b0, 2'd0, 32'h0, 4'h0); #1;
    chk("lk_wait0_c", m0_if.waitrequest, 1'b0);
    chk("lk_addr_c", mem_address, 2'd0);
    @(negedge clk); idle_all(); #1;
    chk("lk_rdv0", m0_if.readdatavalid, 1'b1);
    chk("lk_rdata0", m0_if.readdata, 32'h0000_CC00);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
